vga_text_pixel_source: RTL

Text-mode pixel source that answers the VGA signal generator's pixel requests. It takes each `req`/`row`/`column` request, looks up the character cell in an external character RAM and the glyph row in an external font ROM, then maps the pixel through a 16-entry palette. It drives the 8-bit `pixel_data` that feeds the generator's `nextVGAdata`. It sits between the CPU-visible video memory and the VGA timing block, and adds a blinking hardware cursor.

---
 rtl/vga_text_pixel_source.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/vga_text_pixel_source.sv
// Text-mode pixel source: character RAM -> font ROM -> palette.
// Four-stage request pipeline with a blinking hardware cursor.
`timescale 1ns/1ps
module vga_text_pixel_source #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [8:0]  row,
  input  logic [9:0]  column,
  output logic [7:0]  pixel_data,
  output logic [12:0] char_addr,
  input  logic [15:0] char_data,
  output logic [10:0] glyph_addr,
  input  logic [7:0]  glyph_data,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [7:0]  cfg_wdata
);

  localparam logic [7:0] LastFrame = 8'(BLINK_FRAMES - 1);

  logic [7:0]  palette [16];
  logic [6:0]  curCol;
  logic [5:0]  curRow;
  logic        curEn;
  logic [7:0]  frameCnt;
  logic        blinkPhase;

  logic        v0, v1, v2, v3;
  logic [2:0]  rowLo0, rowLo1;
  logic [2:0]  colLo0, colLo1, colLo2, colLo3;
  logic        inRange0, inRange1, inRange2, inRange3;
  logic        hit0, hit1;
  logic [3:0]  fg2, bg2, fg3, bg3;

  logic [12:0] cellRow;
  logic [12:0] cellAddr;
  logic        frameStart;
  logic        swap;
  logic [2:0]  bitSel;
  logic [3:0]  palIdx;

  // 80 cells per text row: r*64 + r*16 + c, kept at full 13 bits
  assign cellRow    = {7'd0, row[8:3]};
  assign cellAddr   = (cellRow << 6) + (cellRow << 4)
                    + {6'd0, column[9:3]};
  assign frameStart = req && (row == 9'd0) && (column == 10'd0);
  assign swap       = hit1 && curEn && blinkPhase;
  assign bitSel     = 3'd7 - colLo3;
  assign palIdx     = glyph_data[bitSel] ? fg3 : bg3;

  // Configuration writes: palette, cursor position and enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) palette[i] <= 8'h00;
      palette[15] <= 8'hFF;
      curCol      <= '0;
      curRow      <= '0;
      curEn       <= 1'b0;
    end else if (cfg_we) begin
      unique case (1'b1)
        !cfg_addr[4]:        palette[cfg_addr[3:0]] <= cfg_wdata;
        cfg_addr == 5'd16:   curCol <= cfg_wdata[6:0];
        cfg_addr == 5'd17:   curRow <= cfg_wdata[5:0];
        cfg_addr == 5'd18:   curEn  <= cfg_wdata[0];
        default: ;
      endcase
    end
  end

  // Frame counter advances on frame-start requests and drives the blink
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frameCnt   <= '0;
      blinkPhase <= 1'b0;
    end else if (frameStart) begin
      if (frameCnt == LastFrame) begin
        frameCnt   <= '0;
        blinkPhase <= ~blinkPhase;
      end else begin
        frameCnt <= frameCnt + 8'd1;
      end
    end
  end

  // Stage 0: issue character RAM address and capture request sidebands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0        <= 1'b0;
      char_addr <= '0;
      rowLo0    <= '0;
      colLo0    <= '0;
      inRange0  <= 1'b0;
      hit0      <= 1'b0;
    end else begin
      v0 <= req;
      if (req) begin
        char_addr <= cellAddr;
        rowLo0    <= row[2:0];
        colLo0    <= column[2:0];
        inRange0  <= (row < 9'd480) && (column < 10'd640);
        hit0      <= (row[8:3] == curRow) && (column[9:3] == curCol);
      end
    end
  end

  // Stage 1: character RAM read in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      rowLo1   <= '0;
      colLo1   <= '0;
      inRange1 <= 1'b0;
      hit1     <= 1'b0;
    end else begin
      v1       <= v0;
      rowLo1   <= rowLo0;
      colLo1   <= colLo0;
      inRange1 <= inRange0;
      hit1     <= hit0;
    end
  end

  // Stage 2: issue font ROM address, latch colours, apply cursor swap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2         <= 1'b0;
      glyph_addr <= '0;
      colLo2     <= '0;
      inRange2   <= 1'b0;
      fg2        <= '0;
      bg2        <= '0;
    end else begin
      v2       <= v1;
      colLo2   <= colLo1;
      inRange2 <= inRange1;
      if (v1) begin
        glyph_addr <= {char_data[7:0], rowLo1};
        fg2        <= swap ? char_data[11:8]  : char_data[15:12];
        bg2        <= swap ? char_data[15:12] : char_data[11:8];
      end
    end
  end

  // Stage 3: font ROM read in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v3       <= 1'b0;
      colLo3   <= '0;
      inRange3 <= 1'b0;
      fg3      <= '0;
      bg3      <= '0;
    end else begin
      v3       <= v2;
      colLo3   <= colLo2;
      inRange3 <= inRange2;
      fg3      <= fg2;
      bg3      <= bg2;
    end
  end

  // Output: palette lookup, blanked outside the visible area
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_data <= 8'h00;
    end else if (v3) begin
      pixel_data <= inRange3 ? palette[palIdx] : 8'h00;
    end
  end

endmodule
